// File: rtl/esfa_loader_pkg.sv
// Shared constants, state encoding and instruction field layout for the ESFA instruction loader.
// LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to every word.
package esfa_loader_pkg;

  localparam int WORD_W         = 56;
  localparam int ADDR_W         = 8;
  localparam int BYTES_PER_WORD = 7;
  localparam int IDX_W          = 3;

`ifdef LOADER_CHECKSUM_EN
  localparam int FRAME_BYTES = BYTES_PER_WORD + 1;
`else
  localparam int FRAME_BYTES = BYTES_PER_WORD;
`endif

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COUNT   = 3'd1;
  localparam logic [2:0] ST_COLLECT = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_ERROR   = 3'd5;
`endif

  // Instruction word fields (bit positions within the 56-bit word).
  localparam int FLD_WILL_WRITE  = 0;
  localparam int FLD_NEW_INDEX   = 8;
  localparam int FLD_NEW_VALUE   = 16;
  localparam int FLD_METADATA    = 24;
  localparam int FLD_IS_METADATA = 32;
  localparam int FLD_SELECTOR    = 40;
  localparam int FLD_ASSERT      = 48;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes LSB-first into a 56-bit word and tracks the byte position
// within the frame; with LOADER_CHECKSUM_EN it also keeps the running XOR.
module word_assembler
  import esfa_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] byte_data,
  output logic       last_byte,
  output word_t      word,
  output logic       csum_ok
);

  logic [IDX_W-1:0] byte_idx;
  word_t            shift_q;

  assign last_byte = (byte_idx == IDX_W'(FRAME_BYTES - 1));

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  // The trailing byte is the checksum, so the word is already complete in shift_q.
  assign word    = shift_q;
  assign csum_ok = (byte_data == xor_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xor_q <= '0;
    end else if (clear || (accept && last_byte)) begin
      xor_q <= '0;
    end else if (accept) begin
      xor_q <= xor_q ^ byte_data;
    end
  end
`else
  // The last data byte is merged on the fly so the word can be latched on its accept edge.
  assign word    = {byte_data, shift_q[WORD_W-1:8]};
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the pack register is datapath, but clearing it keeps bram_din deterministic after reset.
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (accept) begin
      byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
      if (byte_idx < IDX_W'(BYTES_PER_WORD))
        shift_q <= {byte_data, shift_q[WORD_W-1:8]};
    end
  end

endmodule

// File: rtl/instr_word_loader.sv
// Loads a count byte N followed by N packed instruction words from a byte stream into the
// instruction BRAM. Define LOADER_CHECKSUM_EN for per-word XOR checksums and the ERROR state.
module instr_word_loader
  import esfa_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [WORD_W-1:0] bram_din,
  output logic              load_done,
  output logic [7:0]        instr_count,
  output logic              load_err
);

  logic [2:0] state_q;
  logic [7:0] n_q;
  addr_t      word_idx_q;
  addr_t      idx_inc;
  logic       accept;
  logic       asm_clear;
  logic       asm_accept;
  logic       last_byte;
  logic       csum_ok;
  word_t      asm_word;

  assign byte_ready = (state_q == ST_COUNT) || (state_q == ST_COLLECT);
  assign accept     = byte_valid && byte_ready;
  assign load_done  = (state_q == ST_DONE);
  assign idx_inc    = word_idx_q + 8'd1;

`ifdef LOADER_CHECKSUM_EN
  assign load_err  = (state_q == ST_ERROR);
  assign asm_clear = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
`else
  assign load_err  = 1'b0;
  assign asm_clear = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
`endif

  // The count byte is consumed by the FSM, never by the assembler.
  assign asm_accept = accept && (state_q == ST_COLLECT);

  word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .accept    (asm_accept),
    .byte_data (byte_data),
    .last_byte (last_byte),
    .word      (asm_word),
    .csum_ok   (csum_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      word_idx_q  <= '0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      instr_count <= '0;
    end else begin
      // NOTE: default-low here makes bram_we a single-cycle pulse without per-state bookkeeping.
      bram_we <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_COUNT;
            word_idx_q <= '0;
          end
        end
        ST_COUNT: begin
          if (accept) begin
            n_q <= byte_data;
            if (byte_data == 8'd0) begin
              state_q     <= ST_DONE;
              instr_count <= 8'd0;
            end else begin
              state_q <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (accept && last_byte) begin
            if (csum_ok) begin
              state_q   <= ST_WRITE;
              bram_we   <= 1'b1;
              bram_addr <= word_idx_q;
              bram_din  <= asm_word;
            end
`ifdef LOADER_CHECKSUM_EN
            else begin
              state_q <= ST_ERROR;
            end
`endif
          end
        end
        ST_WRITE: begin
          word_idx_q <= idx_inc;
          if (idx_inc == n_q) begin
            state_q     <= ST_DONE;
            instr_count <= n_q;
          end else begin
            state_q <= ST_COLLECT;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q    <= ST_COUNT;
            word_idx_q <= '0;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_ERROR: begin
          if (start) begin
            state_q    <= ST_COUNT;
            word_idx_q <= '0;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
